// File: rtl/reflet_gpio_regs.sv
// GPIO register window: synchronized inputs, output port with set/clear/toggle
// aliases, and a sticky write-one-to-clear rising-edge capture register.
module reflet_gpio_regs #(
    parameter int wordsize       = 16,
    parameter int base_addr_size = 8,
    parameter int base_addr      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [wordsize-1:0]       gpi,
    output logic [wordsize-1:0]       gpo
);

    // One extra bit so the window end (base_addr+5) never wraps past the address width.
    localparam int              AW   = base_addr_size + 1;
    localparam logic [AW-1:0]   BASE = AW'(base_addr);

    localparam logic [2:0] OFF_GPI  = 3'd0;
    localparam logic [2:0] OFF_GPO  = 3'd1;
    localparam logic [2:0] OFF_SET  = 3'd2;
    localparam logic [2:0] OFF_CLR  = 3'd3;
    localparam logic [2:0] OFF_TGL  = 3'd4;
    localparam logic [2:0] OFF_RISE = 3'd5;

    logic [AW-1:0]       addr_ext;
    logic [AW-1:0]       offset;
    logic                hit;
    logic [2:0]          reg_sel;
    logic                wr;
    logic [wordsize-1:0] gpi_p0;
    logic [wordsize-1:0] gpi_p1;
    logic [wordsize-1:0] gpi_p2;
    logic [wordsize-1:0] rise_now;
    logic [wordsize-1:0] rise_clr;
    logic [wordsize-1:0] rise_reg;

    function automatic logic [wordsize-1:0] next_gpo(
        input logic [2:0]          sel,
        input logic [wordsize-1:0] cur,
        input logic [wordsize-1:0] din
    );
        case (sel)
            OFF_GPO: return din;
            OFF_SET: return cur | din;
            OFF_CLR: return cur & ~din;
            OFF_TGL: return cur ^ din;
            default: return cur;
        endcase
    endfunction

    assign addr_ext = {1'b0, addr};
    assign offset   = addr_ext - BASE;
    assign hit      = (addr_ext >= BASE) && (offset <= AW'(5));
    assign reg_sel  = offset[2:0];
    assign wr       = enable && write_en && hit;

    assign rise_now = gpi_p1 & ~gpi_p2;
    assign rise_clr = (wr && reg_sel == OFF_RISE) ? data_in : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpi_p0   <= '0;
            gpi_p1   <= '0;
            gpi_p2   <= '0;
            rise_reg <= '0;
            gpo      <= '0;
        end else begin
            // stage p0/p1: two-flop synchronizer; p2: previous value for edge detect
            gpi_p0   <= gpi;
            gpi_p1   <= gpi_p0;
            gpi_p2   <= gpi_p1;
            // a fresh edge overrides a same-cycle W1C of that bit
            rise_reg <= (rise_reg & ~rise_clr) | rise_now;
            if (wr) begin
                gpo <= next_gpo(reg_sel, gpo, data_in);
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (enable && hit) begin
            case (reg_sel)
                OFF_GPI:  data_out = gpi_p1;
                OFF_GPO:  data_out = gpo;
                OFF_RISE: data_out = rise_reg;
                default:  data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_gpio_regs.sv
// Bench for reflet_gpio_regs: directed register-map scenarios then random bus
// traffic, all compared every cycle against a behavioural register model.
module tb_reflet_gpio_regs;

    localparam int W    = 16;
    localparam int AW   = 8;
    localparam int BASE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          write_en = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic [W-1:0]  gpi = '0;
    logic [W-1:0]  gpo;

    int total = 0;
    int bad   = 0;

    // model state: port value, sticky edges, and the last three gpi samples taken at clock edges
    logic [W-1:0] m_gpo = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_hist [3] = '{default: '0};

    logic         lit_on = 1'b0;
    logic         lit_chk_d = 1'b0;
    logic         lit_chk_g = 1'b0;
    logic [W-1:0] lit_d = '0;
    logic [W-1:0] lit_g = '0;
    string        lit_name = "";

    reflet_gpio_regs #(
        .wordsize(W),
        .base_addr_size(AW),
        .base_addr(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .addr(addr),
        .write_en(write_en),
        .data_in(data_in),
        .data_out(data_out),
        .gpi(gpi),
        .gpo(gpo)
    );

    always #5 clk = ~clk;

    function automatic int off_of(input logic [AW-1:0] a);
        return int'(a) - BASE;
    endfunction

    function automatic logic in_window(input logic [AW-1:0] a);
        return (off_of(a) >= 0) && (off_of(a) <= 5);
    endfunction

    function automatic logic [W-1:0] model_gpo_next(input logic [W-1:0] cur);
        if (!(enable && write_en && in_window(addr))) return cur;
        case (off_of(addr))
            1:       return data_in;
            2:       return cur | data_in;
            3:       return cur & ~data_in;
            4:       return cur ^ data_in;
            default: return cur;
        endcase
    endfunction

    function automatic logic [W-1:0] model_rise_next(input logic [W-1:0] cur);
        logic [W-1:0] clr;
        clr = (enable && write_en && in_window(addr) && off_of(addr) == 5) ? data_in : '0;
        // the synchronized value went 0->1 between the two most recent visible samples
        return (cur & ~clr) | (m_hist[1] & ~m_hist[2]);
    endfunction

    function automatic logic [W-1:0] model_dout();
        if (!(enable && in_window(addr))) return '0;
        case (off_of(addr))
            0:       return m_hist[1];
            1:       return m_gpo;
            5:       return m_rise;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_gpo     <= '0;
            m_rise    <= '0;
            m_hist[0] <= '0;
            m_hist[1] <= '0;
            m_hist[2] <= '0;
        end else begin
            m_gpo     <= model_gpo_next(m_gpo);
            m_rise    <= model_rise_next(m_rise);
            m_hist[0] <= gpi;
            m_hist[1] <= m_hist[0];
            m_hist[2] <= m_hist[1];
        end
    end

    always @(negedge clk) begin
        total++;
        if (data_out !== model_dout()) begin
            bad++;
            $display("FAIL model_dout t=%0t addr=%0d en=%0b got=%h want=%h",
                     $time, addr, enable, data_out, model_dout());
        end
        total++;
        if (gpo !== m_gpo) begin
            bad++;
            $display("FAIL model_gpo t=%0t got=%h want=%h", $time, gpo, m_gpo);
        end
        if (lit_on && lit_chk_d) begin
            total++;
            if (data_out !== lit_d) begin
                bad++;
                $display("FAIL %s data_out got=%h want=%h", lit_name, data_out, lit_d);
            end
        end
        if (lit_on && lit_chk_g) begin
            total++;
            if (gpo !== lit_g) begin
                bad++;
                $display("FAIL %s gpo got=%h want=%h", lit_name, gpo, lit_g);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic cd, input logic [W-1:0] d,
                              input logic cg, input logic [W-1:0] g);
        lit_name  = name;
        lit_chk_d = cd;
        lit_d     = d;
        lit_chk_g = cg;
        lit_g     = g;
        lit_on    = 1'b1;
        @(negedge clk);
        #1;
        lit_on    = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        addr     = 8'd3;
        gpi      = 16'hABCD;
        step();
        step();
        expect_lit("reset_hold", 1'b1, 16'h0000, 1'b1, 16'h0000);

        step();
        reset = 1'b1;
        addr  = 8'd2;
        expect_lit("gpi_before_edge1", 1'b1, 16'h0000, 1'b1, 16'h0000);
        step();
        expect_lit("gpi_after_edge1", 1'b1, 16'h0000, 1'b0, 16'h0000);
        step();
        expect_lit("gpi_after_edge2", 1'b1, 16'hABCD, 1'b1, 16'h0000);

        write_en = 1'b1;
        data_in  = 16'h0007;
        addr     = 8'd0;
        step();
        addr = 8'd2;
        step();
        write_en = 1'b0;
        addr     = 8'd3;
        expect_lit("ro_miss_gpo", 1'b1, 16'h0000, 1'b1, 16'h0000);
        addr = 8'd0;
        expect_lit("miss_read", 1'b1, 16'h0000, 1'b0, 16'h0000);

        write_en = 1'b1;
        addr     = 8'd3;
        data_in  = 16'h00F0;
        step();
        write_en = 1'b0;
        expect_lit("gpo_write", 1'b1, 16'h00F0, 1'b1, 16'h00F0);
        write_en = 1'b1;
        addr     = 8'd4;
        data_in  = 16'h000F;
        step();
        write_en = 1'b0;
        expect_lit("gpo_set", 1'b1, 16'h0000, 1'b1, 16'h00FF);
        write_en = 1'b1;
        addr     = 8'd5;
        data_in  = 16'h0030;
        step();
        write_en = 1'b0;
        expect_lit("gpo_clr", 1'b1, 16'h0000, 1'b1, 16'h00CF);
        write_en = 1'b1;
        addr     = 8'd6;
        data_in  = 16'hFFFF;
        step();
        write_en = 1'b0;
        expect_lit("gpo_tgl", 1'b1, 16'h0000, 1'b1, 16'hFF30);

        addr = 8'd7;
        expect_lit("rise_after_reset", 1'b1, 16'hABCD, 1'b0, 16'h0000);
        write_en = 1'b1;
        data_in  = 16'h000D;
        step();
        write_en = 1'b0;
        expect_lit("rise_w1c", 1'b1, 16'hABC0, 1'b0, 16'h0000);
        gpi = 16'hFBCD;
        step();
        step();
        expect_lit("rise_not_yet", 1'b1, 16'hABC0, 1'b0, 16'h0000);
        step();
        expect_lit("rise_new_edges", 1'b1, 16'hFBC0, 1'b0, 16'h0000);

        gpi = 16'hFBCF;
        step();
        step();
        write_en = 1'b1;
        data_in  = 16'h0002;
        step();
        write_en = 1'b0;
        expect_lit("rise_edge_beats_w1c", 1'b1, 16'hFBC2, 1'b0, 16'h0000);
        write_en = 1'b1;
        step();
        write_en = 1'b0;
        expect_lit("rise_w1c_after", 1'b1, 16'hFBC0, 1'b0, 16'h0000);

        enable   = 1'b0;
        addr     = 8'd3;
        data_in  = 16'h1234;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
        expect_lit("disabled_write", 1'b1, 16'h0000, 1'b1, 16'hFF30);
        for (int a = 0; a < 10; a++) begin
            addr = AW'(a);
            expect_lit("disabled_read", 1'b1, 16'h0000, 1'b0, 16'h0000);
        end

        enable = 1'b1;
        addr   = 8'd7;
        step();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        expect_lit("async_reset", 1'b1, 16'h0000, 1'b1, 16'h0000);
        step();
        step();
        step();
        expect_lit("recapture", 1'b1, 16'hFBCF, 1'b1, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            addr     = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 10));
            write_en = $urandom_range(0, 1) == 1;
            data_in  = W'($urandom);
            if ($urandom_range(0, 2) == 0) gpi = gpi ^ W'($urandom) & W'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reflet_gpio_regs.md
# reflet_gpio_regs

Memory-mapped general-purpose I/O peripheral for the Reflet microcontroller system bus. It exposes a synchronized input port, a writable output port with set, clear and toggle aliases, and a sticky rising-edge capture register. All registers sit in a small register window at a parameterizable base address on the peripheral bus.

## Interface
- `wordsize`, default 16: width of bus data, GPI and GPO.
- `base_addr_size`, default 8: width of `addr`.
- `base_addr`, default 0: bus address of register offset 0. The window spans `base_addr` to `base_addr+5`.
- `clk` input, 1 bit: single system clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
- `enable` input, 1 bit: peripheral select. When 0, no write takes effect and `data_out` = 0.
- `addr` input, `base_addr_size` bits: bus address.
- `write_en` input, 1 bit: write strobe, sampled at the clock edge.
- `data_in` input, `wordsize` bits: write data.
- `data_out` output, `wordsize` bits: read data, combinational.
- `gpi` input, `wordsize` bits: external inputs, asynchronous to `clk`.
- `gpo` output, `wordsize` bits: registered output port.

## Operation
- Offset decode: offset = `addr` − `base_addr`.
  - Hit only when `addr` ≥ `base_addr` and offset ≤ 5. There is no wrap-around.
  - Addresses below `base_addr` or above `base_addr+5` are misses.
- Register map (by offset):
  - 0 GPI (RO): value of the second GPI synchronizer stage. Writes are ignored.
  - 1 GPO (RW): write loads `gpo` := `data_in`. Read returns `gpo`.
  - 2 GPO_SET (WO): write does `gpo` := `gpo` | `data_in`. Reads 0.
  - 3 GPO_CLR (WO): write does `gpo` := `gpo` & ~`data_in`. Reads 0.
  - 4 GPO_TGL (WO): write does `gpo` := `gpo` ^ `data_in`. Reads 0.
  - 5 RISE (R/W1C): bit n sets when the synchronized GPI bit n goes 0→1. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- A write occurs at a rising clock edge when `enable` & `write_en` & hit.
- Read: `data_out` = selected register when `enable` & hit, else 0. `data_out` is independent of `write_en`.
- GPI synchronizer: two flops per bit, sync1 ← `gpi`, sync2 ← sync1.
- Edge detect: a third flop prev ← sync2. rise_n = sync2 & ~prev.
- RISE same-cycle conflict: a new rising edge on a bit wins over a W1C clear of that bit in the same cycle; the bit stays 1.
- Out-of-window writes have no effect on any state.

## Timing
- Reset (`reset` = 0, asynchronous) clears `gpo`, sync1, sync2, prev and RISE to 0 immediately.
- Reset value of outputs:
  - `gpo` = 0.
  - `data_out` = 0, except when offset 1 is selected, where it also reads 0.
- Writes take effect at the clock edge. `gpo` and the read-back value change in the same cycle after that edge, with 1 cycle of write latency.
- Reads are combinational: zero-cycle latency from `addr` or `enable`.
- GPI latency: a `gpi` change is visible at offset 0 after 2 rising edges. The corresponding RISE bit sets at the 3rd edge.
- After reset release with constant nonzero `gpi`: RISE captures every bit that is 1 in `gpi`, because prev resets to 0.
- Reset asserted mid-operation aborts any write in progress and clears all state. Behaviour after release is as from power-up.

## Test plan
- Reset then offset-0 read: hold `reset` = 0, then release with `gpi` = 0xABCD. Read `base_addr` (addr 2 with `base_addr` = 2) → `data_out` = 0 before the 2nd edge, then 0xABCD. `gpo` stays 0 throughout reset.
- Write to read-only and out-of-window addresses: with `write_en` = 1 and `data_in` = 7, write addr 0 (miss) and addr 2 (GPI, RO). Then read addr 3 → 0x0000 and addr 0 → 0. `gpo` = 0.
- GPO write and aliases:
  - Write 0x00F0 to offset 1 → `gpo` = 0x00F0.
  - SET 0x000F → `gpo` = 0x00FF.
  - CLR 0x0030 → `gpo` = 0x00CF.
  - TGL 0xFFFF → `gpo` = 0xFF30.
  - Reading offsets 2, 3 and 4 returns 0.
- RISE capture and clear:
  - After reset release with `gpi` = 0xABCD, read offset 5 → 0xABCD.
  - W1C 0x000D → read 0xABC0.
  - Drive `gpi` = 0xFBCD → after 3 edges, read 0xFBC0.
  - Issue a simultaneous edge and W1C on the same bit → the bit stays 1.
- `enable` gating: with `enable` = 0, write offset 1 = 0x1234 → `gpo` unchanged and `data_out` = 0 at all addresses.
- Asynchronous reset mid-run: with `gpo` = 0xFF30, pulse `reset` low between clock edges → `gpo` = 0 immediately and RISE = 0.
